// File: rtl/sync_fifo_v3.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_v3 #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_LEN = 4,
    parameter int AF_THRESH = 2**DEPTH_LEN - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 i_flush,
    input  logic                 i_clr_err,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
    output logic [DEPTH_LEN:0]   o_count,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam int DEPTH = 2**DEPTH_LEN;
    localparam int CW    = DEPTH_LEN + 1;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
        $error("sync_fifo_v3: AF_THRESH must be <= DEPTH and AE_THRESH < DEPTH");
    end

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [DEPTH_LEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 wr_acc, rd_acc;
    logic                 ovf_set, unf_set;

    assign o_full         = (count_q == FULL_C);
    assign o_empty        = (count_q == '0);
    assign o_almost_full  = (count_q >= AF_C);
    assign o_almost_empty = (count_q <= AE_C);
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

    // Flush swallows both requests, so it also masks error detection.
    always_comb begin
        rd_acc  = rd_en && !o_empty && !i_flush;
        wr_acc  = wr_en && (!o_full || rd_acc) && !i_flush;
        ovf_set = wr_en && !wr_acc && !i_flush;
        unf_set = rd_en && o_empty && !i_flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // A new error event in the clear cycle keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (i_clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (unf_set) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign o_data = o_empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (rd_acc) begin
            data_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_v3.sv
// Self-checking bench for sync_fifo_v3: vector table plus data scoreboard.
// Data checks follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_v3;

    localparam int W  = 8;
    localparam int DL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          wr, rd, fl, clr;
    logic [W-1:0]  dout;
    logic          full, empty, afull, aempty, ovf, unf;
    logic [DL:0]   cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         wr;
        logic         rd;
        logic         fl;
        logic         clr;
        logic [W-1:0] d;
        int           cnt;
        logic         ovf;
        logic         unf;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] last_data;

    sync_fifo_v3 #(
        .WIDTH     (W),
        .DEPTH_LEN (DL),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_data         (din),
        .wr_en          (wr),
        .rd_en          (rd),
        .i_flush        (fl),
        .i_clr_err      (clr),
        .o_data         (dout),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (cnt),
        .o_overflow     (ovf),
        .o_underflow    (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int c,
                             input logic o, input logic u);
        chk({tag, " count"}, int'(cnt), c);
        chk({tag, " full"}, int'(full), int'(c == 4));
        chk({tag, " empty"}, int'(empty), int'(c == 0));
        chk({tag, " afull"}, int'(afull), int'(c >= 3));
        chk({tag, " aempty"}, int'(aempty), int'(c <= 1));
        chk({tag, " ovf"}, int'(ovf), int'(o));
        chk({tag, " unf"}, int'(unf), int'(u));
    endtask

    function automatic void add(input logic w, input logic r, input logic f,
                                input logic c, input logic [W-1:0] d,
                                input int n, input logic o, input logic u);
        vec_t v;
        v.wr = w; v.rd = r; v.fl = f; v.clr = c;
        v.d = d; v.cnt = n; v.ovf = o; v.unf = u;
        vecs.push_back(v);
    endfunction

    initial begin
        // wr rd fl clr data   cnt ovf unf
        add(1, 0, 0, 0, 8'h11, 1, 0, 0);
        add(1, 0, 0, 0, 8'h22, 2, 0, 0);
        add(1, 0, 0, 0, 8'h33, 3, 0, 0);
        add(1, 0, 0, 0, 8'h44, 4, 0, 0);
        add(1, 0, 0, 0, 8'h55, 4, 1, 0);
        add(0, 1, 0, 0, 8'h00, 3, 1, 0);
        add(0, 1, 0, 0, 8'h00, 2, 1, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 1, 8'h00, 0, 0, 0);
        add(1, 0, 0, 0, 8'h11, 1, 0, 0);
        add(1, 0, 0, 0, 8'h22, 2, 0, 0);
        add(1, 0, 0, 0, 8'h33, 3, 0, 0);
        add(1, 0, 0, 0, 8'h44, 4, 0, 0);
        add(1, 1, 0, 0, 8'h66, 4, 0, 0);
        add(0, 1, 0, 0, 8'h00, 3, 0, 0);
        add(0, 1, 0, 0, 8'h00, 2, 0, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(0, 1, 0, 0, 8'h00, 0, 0, 0);
        add(1, 1, 0, 0, 8'h77, 1, 0, 1);
        add(0, 0, 0, 1, 8'h00, 1, 0, 0);
        add(0, 1, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 0, 8'hA1, 1, 0, 0);
        add(1, 0, 0, 0, 8'hA2, 2, 0, 0);
        add(1, 0, 0, 0, 8'hA3, 3, 0, 0);
        add(1, 0, 1, 0, 8'hA4, 0, 0, 0);
        add(1, 0, 0, 0, 8'h99, 1, 0, 0);
        add(0, 0, 0, 0, 8'h00, 1, 0, 0);
        add(0, 1, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 0, 0, 1);

        rst_n = 1'b0;
        wr = 0; rd = 0; fl = 0; clr = 0; din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0);
        chk("reset data", int'(dout), 0);
        last_data = '0;

        foreach (vecs[i]) begin
            logic         rd_ok, wr_ok, popped;
            logic [W-1:0] exp_d;
            string        tag;
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            wr = vecs[i].wr; rd = vecs[i].rd;
            fl = vecs[i].fl; clr = vecs[i].clr;
            din = vecs[i].d;
            #1;
`ifdef SYNC_FIFO_FWFT_EN
            chk({tag, " head"}, int'(dout),
                sb.size() > 0 ? int'(sb[0]) : 0);
`endif
            popped = 1'b0;
            exp_d  = last_data;
            if (vecs[i].fl) begin
                sb.delete();
            end else begin
                rd_ok = vecs[i].rd && sb.size() > 0;
                wr_ok = vecs[i].wr && (sb.size() < 4 || rd_ok);
                if (rd_ok) begin
                    exp_d  = sb.pop_front();
                    popped = 1'b1;
                end
                if (wr_ok) sb.push_back(vecs[i].d);
            end
            @(posedge clk);
            #1;
            chk_state(tag, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
`ifndef SYNC_FIFO_FWFT_EN
            chk({tag, popped ? " rdata" : " hold"}, int'(dout), int'(exp_d));
`endif
            last_data = exp_d;
        end

        @(negedge clk);
        wr = 0; rd = 0; fl = 0; clr = 0;
        din = 8'h5A;
        wr = 1;
        @(posedge clk);
        #1;
        chk("pre-rst count", int'(cnt), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async rst", 0, 0, 0);
        chk("async rst data", int'(dout), 0);
        wr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_state("post rst", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
